// File: rtl/fft_pkg.sv
// Shared definitions for the FFT sequencer: state encoding, default
// geometry and a width helper used to size counters and indices.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } fft_state_e;

  localparam int FFT_N_BLOCKS_DEFAULT       = 4;
  localparam int FFT_TIMEOUT_CYCLES_DEFAULT = 16;

  // Bits needed to index 'value' items; never narrower than one bit so
  // that degenerate configurations still produce a legal vector.
  function automatic int fft_width(input int value);
    int w;
    w = $clog2(value);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/fft_seq_timeout_cnt.sv
// Loadable saturating up-counter with synchronous clear, count enable and
// a terminal-count flag. Used to time how long the sequencer waits for the
// datapath completion flag.
module fft_seq_timeout_cnt #(
  parameter int W       = 5,
  parameter int MAX_VAL = 16,
  parameter int TC_VAL  = 15
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  localparam logic [W-1:0] MAX_L = W'(MAX_VAL);
  localparam logic [W-1:0] TC_L  = W'(TC_VAL);

  logic [W-1:0] count_r;

  // Count register: clear beats load beats increment; holds at MAX_L.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != MAX_L)) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == TC_L);

endmodule

// File: rtl/fft_seq_ctrl.sv
// FFT load/complete sequencer. Steps N_BLOCKS one-hot load enables with a
// data_valid strobe, waits for the datapath completion flag and pulses done.
// Adds busy, abort, a completion timeout with sticky error, and block index.
// Optional build macro FFT_SEQ_CTRL_BACK2BACK_EN lets a start seen during
// DONE go straight to LOAD, removing the IDLE bubble between transforms.
module fft_seq_ctrl
  import fft_pkg::*;
#(
  parameter  int N_BLOCKS       = FFT_N_BLOCKS_DEFAULT,
  parameter  int TIMEOUT_CYCLES = FFT_TIMEOUT_CYCLES_DEFAULT,
  localparam int IDX_W          = fft_width(N_BLOCKS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic                fft_done,
  output logic                data_valid,
  output logic [N_BLOCKS-1:0] enable_block,
  output logic [IDX_W-1:0]    block_idx,
  output logic                busy,
  output logic                done,
  output logic                timeout_err
);

  localparam int             CNT_W      = fft_width(TIMEOUT_CYCLES + 1);
  localparam int             TC_VAL     = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic           TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BLOCKS - 1);

  fft_state_e            state_r;
  logic                  data_valid_r;
  logic [N_BLOCKS-1:0]   enable_block_r;
  logic [IDX_W-1:0]      block_idx_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  timeout_err_r;

  logic                  cnt_clear_s;
  logic                  cnt_en_s;
  logic                  cnt_tc_s;
  logic                  timeout_fire_s;
  logic [IDX_W-1:0]      next_idx_s;

  // One-hot load enable for a given block index.
  function automatic logic [N_BLOCKS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_BLOCKS-1:0] one;
    one = {{(N_BLOCKS-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  // The wait counter only runs in WAIT and is held at zero elsewhere, so it
  // reads zero on the first WAIT cycle.
  assign cnt_clear_s    = (state_r != ST_WAIT);
  assign cnt_en_s       = (state_r == ST_WAIT);
  assign timeout_fire_s = TIMEOUT_EN & cnt_tc_s;
  assign next_idx_s     = block_idx_r + IDX_W'(1);

  fft_seq_timeout_cnt #(
    .W       (CNT_W),
    .MAX_VAL (TIMEOUT_CYCLES),
    .TC_VAL  (TC_VAL)
  ) u_timeout_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (cnt_clear_s),
    .load     (1'b0),
    .load_val ({CNT_W{1'b0}}),
    .en       (cnt_en_s),
    .tc       (cnt_tc_s)
  );

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= ST_IDLE;
      data_valid_r   <= 1'b0;
      enable_block_r <= '0;
      block_idx_r    <= '0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      timeout_err_r  <= 1'b0;
    end else if (abort) begin
      // Abort outranks start, completion and timeout; the error flag holds.
      state_r        <= ST_IDLE;
      data_valid_r   <= 1'b0;
      enable_block_r <= '0;
      block_idx_r    <= '0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r        <= ST_LOAD;
            data_valid_r   <= 1'b1;
            enable_block_r <= onehot('0);
            block_idx_r    <= '0;
            busy_r         <= 1'b1;
            timeout_err_r  <= 1'b0;
          end else begin
            state_r        <= ST_IDLE;
            data_valid_r   <= 1'b0;
            enable_block_r <= '0;
            block_idx_r    <= '0;
            busy_r         <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (block_idx_r == LAST_IDX) begin
            state_r        <= ST_WAIT;
            data_valid_r   <= 1'b0;
            enable_block_r <= '0;
            block_idx_r    <= '0;
            busy_r         <= 1'b1;
          end else begin
            state_r        <= ST_LOAD;
            data_valid_r   <= 1'b1;
            enable_block_r <= onehot(next_idx_s);
            block_idx_r    <= next_idx_s;
            busy_r         <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (fft_done) begin
            // Completion wins even when the timeout fires in the same cycle.
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b1;
          end else if (timeout_fire_s) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b1;
          end else begin
            state_r <= ST_WAIT;
            busy_r  <= 1'b1;
          end
        end
        ST_DONE: begin
`ifdef FFT_SEQ_CTRL_BACK2BACK_EN
          if (start) begin
            state_r        <= ST_LOAD;
            data_valid_r   <= 1'b1;
            enable_block_r <= onehot('0);
            block_idx_r    <= '0;
            busy_r         <= 1'b1;
            timeout_err_r  <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
`else
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
`endif
        end
        default: begin
          state_r        <= ST_IDLE;
          data_valid_r   <= 1'b0;
          enable_block_r <= '0;
          block_idx_r    <= '0;
          busy_r         <= 1'b0;
        end
      endcase
    end
  end

  assign data_valid   = data_valid_r;
  assign enable_block = enable_block_r;
  assign block_idx    = block_idx_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed bench for fft_seq_ctrl: a default instance (4 blocks, timeout 16)
// and a second instance with 8 blocks and timeout 4.
module tb_fft_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, abort, fft_done;
  logic       data_valid, busy, done, timeout_err;
  logic [3:0] enable_block;
  logic [1:0] block_idx;

  logic       start8, abort8, fft_done8;
  logic       data_valid8, busy8, done8, timeout_err8;
  logic [7:0] enable_block8;
  logic [2:0] block_idx8;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fft_seq_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .fft_done     (fft_done),
    .data_valid   (data_valid),
    .enable_block (enable_block),
    .block_idx    (block_idx),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err)
  );

  fft_seq_ctrl #(.N_BLOCKS(8), .TIMEOUT_CYCLES(4)) dut8 (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start8),
    .abort        (abort8),
    .fft_done     (fft_done8),
    .data_valid   (data_valid8),
    .enable_block (enable_block8),
    .block_idx    (block_idx8),
    .busy         (busy8),
    .done         (done8),
    .timeout_err  (timeout_err8)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic dv, input logic [3:0] en,
                      input logic [1:0] idx, input logic bsy, input logic dn,
                      input logic terr);
    cmp({tag, ".data_valid"},   {31'd0, data_valid},   {31'd0, dv});
    cmp({tag, ".enable_block"}, {28'd0, enable_block}, {28'd0, en});
    cmp({tag, ".block_idx"},    {30'd0, block_idx},    {30'd0, idx});
    cmp({tag, ".busy"},         {31'd0, busy},         {31'd0, bsy});
    cmp({tag, ".done"},         {31'd0, done},         {31'd0, dn});
    cmp({tag, ".timeout_err"},  {31'd0, timeout_err},  {31'd0, terr});
  endtask

  task automatic chk8(input string tag, input logic dv, input logic [7:0] en,
                      input logic [2:0] idx, input logic bsy, input logic dn,
                      input logic terr);
    cmp({tag, ".data_valid"},   {31'd0, data_valid8},   {31'd0, dv});
    cmp({tag, ".enable_block"}, {24'd0, enable_block8}, {24'd0, en});
    cmp({tag, ".block_idx"},    {29'd0, block_idx8},    {29'd0, idx});
    cmp({tag, ".busy"},         {31'd0, busy8},         {31'd0, bsy});
    cmp({tag, ".done"},         {31'd0, done8},         {31'd0, dn});
    cmp({tag, ".timeout_err"},  {31'd0, timeout_err8},  {31'd0, terr});
  endtask

  // Advance one clock; sample and drive 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Called in load cycle c1; checks c1..c4 and the first WAIT cycle.
  task automatic load4(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk4($sformatf("%s_load%0d", tag, k), 1'b1, 4'(1 << k), 2'(k), 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk4({tag, "_wait0"}, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; fft_done = 1'b0;
    start8 = 1'b0; abort8 = 1'b0; fft_done8 = 1'b0;
    #3;
    chk4("reset", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    chk8("reset8", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    #9 reset_n = 1'b1;
    tick();
    chk4("idle", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Basic run: start at c0, fft_done in c6, done in c7.
    start = 1'b1; tick(); start = 1'b0;
    load4("t1");
    tick();
    chk4("t1_wait1", 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    chk4("t1_done", 1'b0, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk4("t1_idle", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Timeout: 16 WAIT cycles without fft_done, sticky error.
    start = 1'b1; tick(); start = 1'b0;
    load4("t2");
    repeat (15) tick();
    chk4("t2_w15", 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk4("t2_timeout", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    chk4("t2_idle_fftdone", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk4("t2_abort_hold", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    load4("t2b");
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    chk4("t2b_done", 1'b0, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk4("t2b_idle", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Abort in load cycle 2, then a stray fft_done.
    start = 1'b1; tick(); start = 1'b0;
    chk4("t3_c1", 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk4("t3_c2", 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
    abort = 1'b1; tick(); abort = 1'b0;
    chk4("t3_abort", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    chk4("t3_stray", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk4("t3_stray2", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Abort in WAIT, then abort together with start in IDLE.
    start = 1'b1; tick(); start = 1'b0;
    load4("t3w");
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk4("t3w_abort", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    chk4("t3_abort_start", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Start held high throughout: no restarts in LOAD/WAIT.
    start = 1'b1; tick();
    load4("t4");
    tick();
    chk4("t4_wait1", 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    chk4("t4_done", 1'b0, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
`ifdef FFT_SEQ_CTRL_BACK2BACK_EN
    chk4("t4_b2b_load", 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
`else
    chk4("t4_bubble", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk4("t4_reload", 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
`endif
    start = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
    chk4("t4_clean", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // fft_done ignored in LOAD; fft_done coincident with terminal count.
    start = 1'b1; tick(); start = 1'b0;
    fft_done = 1'b1;
    load4("t5");
    fft_done = 1'b0;
    repeat (15) tick();
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    chk4("t5_coincident", 1'b0, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk4("t5_idle", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset during WAIT; start honoured at the first edge.
    start = 1'b1; tick(); start = 1'b0;
    load4("t6");
    tick(); tick();
    #1 reset_n = 1'b0;
    #1 chk4("t6_async_reset", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    #1 reset_n = 1'b1;
    tick(); start = 1'b0;
    chk4("t6_first_edge", 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
    abort = 1'b1; tick(); abort = 1'b0;

    // Eight-block instance with a four-cycle timeout.
    start8 = 1'b1; tick(); start8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk8($sformatf("t7_load%0d", k), 1'b1, 8'(1 << k), 3'(k), 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk8("t7_wait0", 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    chk8("t7_wait3", 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk8("t7_timeout", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
